uart_tx_frame: RTL

Parametrised UART transmitter; next generation of the fixed 8N1 `uart_tx`. Serialises one word per `tx_trig` onto `rs232_tx`, with configurable:
- data width
- clocks-per-bit divisor
- stop-bit count
- optional compile-time parity

Adds a ready/busy/done handshake so an upstream controller or FIFO can stream frames back-to-back. Sits between the system bus/FIFO and the board RS-232 pin.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_cnt.sv | 37 +++
 rtl/uart_tx_frame.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and legal parameter ranges.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_tx_state_t;

    localparam logic UART_PAR_EVEN = 1'b0;
    localparam logic UART_PAR_ODD  = 1'b1;

    localparam int unsigned UART_DATA_W_MIN    = 5;
    localparam int unsigned UART_DATA_W_MAX    = 9;
    localparam int unsigned UART_STOP_BITS_MIN = 1;
    localparam int unsigned UART_STOP_BITS_MAX = 2;
    localparam int unsigned UART_CLK_DIV_MIN   = 2;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLK_DIV-1, restarts on clr or at the end of each bit.
// bit_pre flags the cycle before bit_end so the parent can register a last-cycle pulse.
module uart_baud_cnt #(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    output logic bit_end,
    output logic bit_pre
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLK_DIV - 2);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end = (cnt_q == CNT_LAST);
    assign bit_pre = (cnt_q == CNT_PRE);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with ready/busy/done handshake; all outputs registered.
// Define UART_TX_PARITY_EN to add a parity bit and the parity_odd port.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CLK_DIV   = 434,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_trig,
`ifdef UART_TX_PARITY_EN
    input  logic              parity_odd,
`endif
    output logic              tx_ready,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              rs232_tx
);

    if (DATA_W < UART_DATA_W_MIN || DATA_W > UART_DATA_W_MAX) begin : g_bad_data_w
        $error("uart_tx_frame: DATA_W=%0d outside %0d..%0d", DATA_W, UART_DATA_W_MIN, UART_DATA_W_MAX);
    end
    if (STOP_BITS < UART_STOP_BITS_MIN || STOP_BITS > UART_STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS=%0d outside %0d..%0d", STOP_BITS, UART_STOP_BITS_MIN,
               UART_STOP_BITS_MAX);
    end
    if (CLK_DIV < UART_CLK_DIV_MIN) begin : g_bad_clk_div
        $error("uart_tx_frame: CLK_DIV=%0d below %0d", CLK_DIV, UART_CLK_DIV_MIN);
    end

    localparam int unsigned BCW = $clog2(DATA_W);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_W - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    uart_tx_state_t    state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BCW-1:0]    bitcnt_q, bitcnt_d;
    logic              line_q, line_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;
    logic              bit_end;
    logic              bit_pre;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    assign accept = tx_trig && ready_q;

    // Held clear through IDLE so every frame's bit edges align to its acceptance edge.
    uart_baud_cnt #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (state_q == ST_IDLE),
        .bit_end (bit_end),
        .bit_pre (bit_pre)
    );

    // Outputs are decoded from the next state so they change on the same edge as the FSM.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d  = tx_data;
                    bitcnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    par_d    = (^tx_data) ^ parity_odd;
`endif
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bitcnt_q == LAST_DATA) begin
                        bitcnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d  = ST_PARITY;
`else
                        state_d  = ST_STOP;
`endif
                    end else begin
                        bitcnt_d = bitcnt_q + BCW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bitcnt_q == LAST_STOP && bit_pre) begin
                    done_d = 1'b1;
                end
                if (bit_end) begin
                    if (bitcnt_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                    end else begin
                        bitcnt_d = bitcnt_q + BCW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        line_d = 1'b1;
        case (state_d)
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: line_d = par_d;
`endif
            default:   line_d = 1'b1;
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = ~ready_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            line_q   <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            line_q   <= line_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign rs232_tx = line_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule
